// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
//   rx_state_e  - receiver FSM states
//   OVERSAMPLE  - stb_sample strobes per bit period
//   SAMPLE_MID  - sample-counter value at which a bit is decided
//   LAST_BIT    - bit index of the final data bit
//   majority3   - 2-of-3 vote, used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SAMPLE_MID = 4'd8;
  localparam logic [2:0]  LAST_BIT   = 3'd7;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous single-bit input.
//   clk     - clock
//   rst_n   - synchronous active-low reset; all stages reset to 1 (idle line)
//   d_i     - asynchronous input
//   q_o     - synchronized output (last stage)
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and a valid/ready output.
//   clk          - clock
//   rst_n        - synchronous active-low reset
//   stb_sample   - one-cycle strobe at 16x baud rate
//   rx_in        - asynchronous serial line, idle high
//   rx_ready     - consumer accepts data_out this cycle
//   data_out     - received byte (LSB first on the line)
//   rx_valid     - data_out holds an unconsumed byte
//   rx_busy      - receiver FSM is not idle
//   rx_frame_err - one-cycle pulse on a low stop bit
//   rx_overrun   - one-cycle pulse when a byte is dropped because the output is full
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote
// of the samples at counter values 6, 7 and 8 instead of the single sample at 8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stb_sample,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam logic [3:0] LastCnt = 4'(OVERSAMPLE - 1);

  logic       rx_s;
  rx_state_e  state_q;
  logic [3:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       done_q;     // stop bit accepted; deliver shift_q on the next edge
  logic       sample_bit;
  logic       at_mid;
  logic       at_last;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_in),
    .q_o  (rx_s)
  );

  assign at_mid  = (cnt_q == SAMPLE_MID);
  assign at_last = (cnt_q == LastCnt);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;  // rx_s captured at counter 6 ([0]) and 7 ([1])

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vote_q <= 2'b00;
    end else if (stb_sample) begin
      if (cnt_q == SAMPLE_MID - 4'd2) vote_q[0] <= rx_s;
      if (cnt_q == SAMPLE_MID - 4'd1) vote_q[1] <= rx_s;
    end
  end

  assign sample_bit = majority3(vote_q[0], vote_q[1], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      done_q       <= 1'b0;
      data_out     <= 8'd0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;

      // Output register: a byte delivered alongside a consuming ready replaces the old one.
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          data_out <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (stb_sample) begin
        cnt_q <= cnt_q + 4'd1;
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q <= StStart;
              cnt_q   <= 4'd0;
            end
          end
          StStart: begin
            if (at_mid && sample_bit) begin
              state_q <= StIdle;  // false start
            end else if (at_last) begin
              state_q   <= StData;
              bit_idx_q <= 3'd0;
            end
          end
          StData: begin
            if (at_mid) shift_q[bit_idx_q] <= sample_bit;
            if (at_last) begin
              if (bit_idx_q == LAST_BIT) state_q <= StStop;
              else bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          StStop: begin
            if (at_mid) begin
              // Return early so the next start edge is caught without delay.
              if (sample_bit) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end else begin
                state_q      <= StWaitIdle;
                rx_frame_err <= 1'b1;
              end
            end
          end
          StWaitIdle: begin
            if (rx_s) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with a byte scoreboard.
// Each line sample slot is four clocks with one stb_sample; bytes are pushed on
// send and compared whenever the DUT hands one over (rx_valid && rx_ready).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb_sample = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_checks = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int hs_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stb_sample  (stb_sample),
    .rx_in       (rx_in),
    .rx_ready    (rx_ready),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  // Inputs change 2 time units after posedge; outputs are observed on negedge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic slot(input logic v);
    rx_in = v;
    repeat (3) tick();
    stb_sample = 1'b1;
    tick();
    stb_sample = 1'b0;
  endtask

  // Start bit, 8 data bits, stop bit, 16 slots each. Data bits selected by
  // flip_mask are inverted at the slot where the DUT counter equals flip_c.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int flip_c,
                            input logic [7:0] flip_mask);
    logic v;
    for (int k = 0; k < 16; k++) slot(1'b0);
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 16; k++) begin
        v = b[n];
        if (flip_mask[n] && (k == flip_c + 1)) v = ~v;
        slot(v);
      end
    end
    for (int k = 0; k < 16; k++) slot(stop_v);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_frame_err) fe_cnt = fe_cnt + 1;
      if (rx_overrun) ov_cnt = ov_cnt + 1;
      if (rx_valid && rx_ready) begin
        hs_cnt = hs_cnt + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          check("scoreboard_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int fe0, ov0, hs0;

    // Reset state
    repeat (3) tick();
    check("reset_data_out", {24'd0, data_out}, 32'h0);
    check("reset_valid", {31'd0, rx_valid}, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);
    check("reset_flags", {30'd0, rx_frame_err, rx_overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (4) slot(1'b1);

    // 0xA5 with ready held high
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; hs0 = hs_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -10, 8'h00);
    repeat (4) slot(1'b1);
    check("a5_handshakes", hs_cnt - hs0, 1);
    check("a5_data_out", {24'd0, data_out}, 32'hA5);
    check("a5_no_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("a5_valid_cleared", {31'd0, rx_valid}, 32'h0);

    // Back-to-back 0x3C, 0xC3 with ready low: second byte overruns
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -10, 8'h00);
    send_frame(8'hC3, 1'b1, -10, 8'h00);
    repeat (2) slot(1'b1);
    check("ovr_data_held", {24'd0, data_out}, 32'h3C);
    check("ovr_valid_high", {31'd0, rx_valid}, 32'h1);
    check("ovr_pulses", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    tick();
    tick();
    check("ovr_valid_cleared", {31'd0, rx_valid}, 32'h0);
    check("ovr_queue_empty", exp_q.size(), 0);

    // 6-sample glitch is a false start
    fe0 = fe_cnt; ov0 = ov_cnt; hs0 = hs_cnt;
    repeat (6) slot(1'b0);
    check("glitch_busy_during", {31'd0, rx_busy}, 32'h1);
    repeat (10) slot(1'b1);
    check("glitch_idle", {31'd0, rx_busy}, 32'h0);
    check("glitch_valid", {31'd0, rx_valid}, 32'h0);
    check("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (hs_cnt - hs0), 0);

    // Framing error on 0x7E, line stays low, then recovery with 0x11
    fe0 = fe_cnt; hs0 = hs_cnt;
    send_frame(8'h7E, 1'b0, -10, 8'h00);
    repeat (4) slot(1'b0);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_valid", {31'd0, rx_valid}, 32'h0);
    check("ferr_wait_idle_busy", {31'd0, rx_busy}, 32'h1);
    check("ferr_no_byte", hs_cnt - hs0, 0);
    repeat (2) slot(1'b1);
    check("ferr_back_idle", {31'd0, rx_busy}, 32'h0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -10, 8'h00);
    repeat (2) slot(1'b1);
    check("ferr_recover_data", {24'd0, data_out}, 32'h11);

    // Reset during data bit 4 of 0xFF
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int k = 0; k < 16; k++) slot(1'b0);
    for (int k = 0; k < 72; k++) slot(1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_data_out", {24'd0, data_out}, 32'h0);
    check("midrst_valid_busy", {30'd0, rx_valid, rx_busy}, 32'h0);
    check("midrst_flags", {30'd0, rx_frame_err, rx_overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (4) slot(1'b1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -10, 8'h00);
    repeat (2) slot(1'b1);
    check("midrst_next_byte", {24'd0, data_out}, 32'h81);
    check("midrst_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

`ifdef UART_RX_MAJORITY_EN
    // Single-sample inversion at counter 7 of every bit is out-voted
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 7, 8'hFF);
    repeat (2) slot(1'b1);
    check("maj_data_out", {24'd0, data_out}, 32'h5A);
`else
    // Single sample at counter 8 decides the bit, so bit 0 is corrupted
    exp_q.push_back(8'h5B);
    send_frame(8'h5A, 1'b1, 8, 8'h01);
    repeat (2) slot(1'b1);
    check("single_data_out", {24'd0, data_out}, 32'h5B);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
